cabac_bin_unpack: RTL and testbench

Read-side consumer of the CABAC syntax-element word buffer. It pulls 76-bit syntax-element words from the buffer with a read-acknowledge / same-cycle-valid handshake, holds one word, and splits it into beats of up to BPC bins per cycle for the binary arithmetic encoder (BAE) under a valid/ready handshake. It sits between the word buffer's read port and the BAE, replacing direct word consumption by binarization.

---
 rtl/cabac_bin_unpack_if.sv | 29 ++
 rtl/cabac_bin_unpack.sv | 154 +++++++++++++++
 tb/tb_cabac_bin_unpack.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cabac_bin_unpack_if.sv
// Bundle between the syntax-element word buffer read port, the bin unpacker and the BAE.
interface cabac_bin_unpack_if #(
    parameter int unsigned BPC = 2
);
    // word buffer read side
    logic               wack_o;
    logic [75:0]        data_i;
    logic               data_valid_i;
    // BAE beat side
    logic               bin_valid_o;
    logic               bae_ready_i;
    logic [2:0]         bin_cnt_o;
    logic [BPC-1:0]     bin_o;
    logic [2*BPC-1:0]   mode_o;
    logic [8:0]         ctx_o;
    logic               last_o;

    // unpacker side
    modport master (
        output wack_o, bin_valid_o, bin_cnt_o, bin_o, mode_o, ctx_o, last_o,
        input  data_i, data_valid_i, bae_ready_i
    );

    // buffer + BAE side
    modport slave (
        input  wack_o, bin_valid_o, bin_cnt_o, bin_o, mode_o, ctx_o, last_o,
        output data_i, data_valid_i, bae_ready_i
    );
endinterface

// File: rtl/cabac_bin_unpack.sv
// Pulls 76-bit syntax-element words and splits each into beats of up to BPC bins for the BAE.
module cabac_bin_unpack #(
    parameter int unsigned BPC = 2
) (
    input  logic                clk,
    input  logic                rst,
    cabac_bin_unpack_if.master  bus
);
    localparam int unsigned MAX_BINS = 16;

    typedef enum logic {IDLE, UNPACK} state_t;

    state_t             state_q, state_d;
    logic [4:0]         ptr_q, ptr_d;
    logic [4:0]         num_q, num_d;
    logic               last_q, last_d;
    logic [15:0]        bins_q, bins_d;
    logic [31:0]        modes_q, modes_d;
    logic [8:0]         ctx_q, ctx_d;

    logic               bin_valid_q, bin_valid_d;
    logic [2:0]         bin_cnt_q, bin_cnt_d;
    logic [BPC-1:0]     bin_q, bin_d;
    logic [2*BPC-1:0]   mode_q, mode_d;
    logic [8:0]         ctx_out_q, ctx_out_d;
    logic               last_out_q, last_out_d;

    logic [4:0]         rem_c, rem_d;
    logic               final_c;
    logic               accept_c;
    logic               wack_c;
    logic               load_c;
    logic [4:0]         in_num_c;
    logic               in_drop_c;
    logic [15:0]        bins_sh_c;
    logic [31:0]        modes_sh_c;
    logic               unused_rsv;

    // Reserved word bits carry nothing for the BAE.
    assign unused_rsv = ^bus.data_i[12:0];

    // Current beat bookkeeping and the word-buffer pop request.
    assign rem_c     = num_q - ptr_q;
    assign final_c   = (rem_c <= 5'(BPC));
    assign accept_c  = (state_q == UNPACK) && bus.bae_ready_i;
    assign wack_c    = !rst && ((state_q == IDLE) || (accept_c && final_c));
    assign load_c    = wack_c && bus.data_valid_i;
    assign in_num_c  = (bus.data_i[74:70] > 5'(MAX_BINS)) ? 5'(MAX_BINS) : bus.data_i[74:70];
    assign in_drop_c = (in_num_c == 5'd0) && !bus.data_i[75];

    // Next held word, pointer and state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        num_d   = num_q;
        last_d  = last_q;
        bins_d  = bins_q;
        modes_d = modes_q;
        ctx_d   = ctx_q;
        if (load_c) begin
            num_d   = in_num_c;
            last_d  = bus.data_i[75];
            bins_d  = bus.data_i[69:54];
            modes_d = bus.data_i[53:22];
            ctx_d   = bus.data_i[21:13];
            ptr_d   = 5'd0;
        end
        case (state_q)
            IDLE: begin
                if (load_c && !in_drop_c) begin
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                if (accept_c) begin
                    if (!final_c) begin
                        ptr_d = ptr_q + 5'(bin_cnt_q);
                    end else if (!(load_c && !in_drop_c)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beat presented in the next cycle, taken from the next word at the next pointer.
    assign rem_d      = num_d - ptr_d;
    assign bins_sh_c  = bins_d >> ptr_d;
    assign modes_sh_c = modes_d >> {ptr_d, 1'b0};

    always_comb begin
        bin_valid_d = 1'b0;
        bin_cnt_d   = 3'd0;
        bin_d       = '0;
        mode_d      = '0;
        ctx_out_d   = 9'd0;
        last_out_d  = 1'b0;
        if (state_d == UNPACK) begin
            bin_valid_d = 1'b1;
            bin_cnt_d   = (rem_d > 5'(BPC)) ? 3'(BPC) : rem_d[2:0];
            ctx_out_d   = ctx_d;
            last_out_d  = last_d && (rem_d <= 5'(BPC));
            for (int i = 0; i < int'(BPC); i++) begin
                if (3'(i) < bin_cnt_d) begin
                    bin_d[i] = bins_sh_c[i];
                    // mode 11 is coded as bypass (01)
                    mode_d[2*i +: 2] = {modes_sh_c[2*i+1] & ~modes_sh_c[2*i], modes_sh_c[2*i]};
                end
            end
        end
    end

    // State, held word and registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 5'd0;
            num_q       <= 5'd0;
            last_q      <= 1'b0;
            bins_q      <= 16'd0;
            modes_q     <= 32'd0;
            ctx_q       <= 9'd0;
            bin_valid_q <= 1'b0;
            bin_cnt_q   <= 3'd0;
            bin_q       <= '0;
            mode_q      <= '0;
            ctx_out_q   <= 9'd0;
            last_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            num_q       <= num_d;
            last_q      <= last_d;
            bins_q      <= bins_d;
            modes_q     <= modes_d;
            ctx_q       <= ctx_d;
            bin_valid_q <= bin_valid_d;
            bin_cnt_q   <= bin_cnt_d;
            bin_q       <= bin_d;
            mode_q      <= mode_d;
            ctx_out_q   <= ctx_out_d;
            last_out_q  <= last_out_d;
        end
    end

    assign bus.wack_o      = wack_c;
    assign bus.bin_valid_o = bin_valid_q;
    assign bus.bin_cnt_o   = bin_cnt_q;
    assign bus.bin_o       = bin_q;
    assign bus.mode_o      = mode_q;
    assign bus.ctx_o       = ctx_out_q;
    assign bus.last_o      = last_out_q;
endmodule

// File: tb/tb_cabac_bin_unpack.sv
// Directed bench for cabac_bin_unpack at BPC=2 and BPC=4.
module tb_cabac_bin_unpack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cabac_bin_unpack_if #(.BPC(2)) if2 ();
    cabac_bin_unpack_if #(.BPC(4)) if4 ();

    cabac_bin_unpack #(.BPC(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
    cabac_bin_unpack #(.BPC(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [75:0] q2[$];
    logic [75:0] q4[$];
    bit pend2 = 1'b0;
    bit pend4 = 1'b0;

    function automatic logic [75:0] mk(input logic lst, input logic [4:0] n, input logic [15:0] b,
                                       input logic [31:0] m, input logic [8:0] c, input logic [12:0] rsv);
        return {lst, n, b, m, c, rsv};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: pop what the last edge consumed, drive ready, then offer a word if requested.
    task automatic drive(input logic rdy);
        @(posedge clk);
        if (pend2) q2.delete(0);
        if (pend4) q4.delete(0);
        #1;
        if2.bae_ready_i = rdy;
        if4.bae_ready_i = rdy;
        #1;
        pend2 = if2.wack_o && (q2.size() > 0);
        if2.data_valid_i = pend2;
        if2.data_i = pend2 ? q2[0] : '0;
        pend4 = if4.wack_o && (q4.size() > 0);
        if4.data_valid_i = pend4;
        if4.data_i = pend4 ? q4[0] : '0;
        @(negedge clk);
    endtask

    task automatic beat2(input string tag, input logic [2:0] cnt, input logic [1:0] b, input logic [3:0] m,
                         input logic [8:0] ctx, input logic lst, input logic wk);
        chk({tag, "_valid"}, 32'(if2.bin_valid_o), 32'd1);
        chk({tag, "_cnt"},   32'(if2.bin_cnt_o),   32'(cnt));
        chk({tag, "_bin"},   32'(if2.bin_o),       32'(b));
        chk({tag, "_mode"},  32'(if2.mode_o),      32'(m));
        chk({tag, "_ctx"},   32'(if2.ctx_o),       32'(ctx));
        chk({tag, "_last"},  32'(if2.last_o),      32'(lst));
        chk({tag, "_wack"},  32'(if2.wack_o),      32'(wk));
    endtask

    task automatic beat4(input string tag, input logic [3:0] b, input logic lst, input logic wk);
        chk({tag, "_valid"}, 32'(if4.bin_valid_o), 32'd1);
        chk({tag, "_cnt"},   32'(if4.bin_cnt_o),   32'd4);
        chk({tag, "_bin"},   32'(if4.bin_o),       32'(b));
        chk({tag, "_mode"},  32'(if4.mode_o),      32'h55);
        chk({tag, "_ctx"},   32'(if4.ctx_o),       32'h1FF);
        chk({tag, "_last"},  32'(if4.last_o),      32'(lst));
        chk({tag, "_wack"},  32'(if4.wack_o),      32'(wk));
    endtask

    initial begin
        if2.data_i = '0; if2.data_valid_i = 1'b0; if2.bae_ready_i = 1'b0;
        if4.data_i = '0; if4.data_valid_i = 1'b0; if4.bae_ready_i = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_wack",  32'(if2.wack_o),      32'd0);
        chk("rst_valid", 32'(if2.bin_valid_o), 32'd0);
        chk("rst_cnt",   32'(if2.bin_cnt_o),   32'd0);
        chk("rst_bin",   32'(if2.bin_o),       32'd0);
        chk("rst_mode",  32'(if2.mode_o),      32'd0);
        chk("rst_ctx",   32'(if2.ctx_o),       32'd0);
        chk("rst_last",  32'(if2.last_o),      32'd0);
        chk("rst_valid4", 32'(if4.bin_valid_o), 32'd0);
        rst = 1'b0;

        // 5-bin word 1,0,1,1,0 ctx 37
        q2.push_back(mk(1'b0, 5'd5, 16'h000D, 32'h0, 9'd37, 13'h0));
        drive(1'b1);
        chk("t1_idle_wack",  32'(if2.wack_o),      32'd1);
        chk("t1_idle_valid", 32'(if2.bin_valid_o), 32'd0);
        drive(1'b1); beat2("t1_b0", 3'd2, 2'b01, 4'h0, 9'd37, 1'b0, 1'b0);
        drive(1'b1); beat2("t1_b1", 3'd2, 2'b11, 4'h0, 9'd37, 1'b0, 1'b0);
        drive(1'b1); beat2("t1_b2", 3'd1, 2'b00, 4'h0, 9'd37, 1'b0, 1'b1);
        drive(1'b1);
        chk("t1_end_valid", 32'(if2.bin_valid_o), 32'd0);
        chk("t1_end_wack",  32'(if2.wack_o),      32'd1);

        // back-to-back words of 4 and 3 bins, second has reserved bits set
        q2.push_back(mk(1'b0, 5'd4, 16'h000B, 32'h0000_00C9, 9'd5, 13'h0));
        q2.push_back(mk(1'b1, 5'd3, 16'h0006, 32'h0, 9'd300, 13'h1ABC));
        drive(1'b1);
        drive(1'b1); beat2("t2_a0", 3'd2, 2'b11, 4'b1001, 9'd5,   1'b0, 1'b0);
        drive(1'b1); beat2("t2_a1", 3'd2, 2'b10, 4'b0100, 9'd5,   1'b0, 1'b1);
        drive(1'b1); beat2("t2_b0", 3'd2, 2'b10, 4'b0000, 9'd300, 1'b0, 1'b0);
        drive(1'b1); beat2("t2_b1", 3'd1, 2'b01, 4'b0000, 9'd300, 1'b1, 1'b1);
        drive(1'b1);
        chk("t2_end_valid", 32'(if2.bin_valid_o), 32'd0);

        // 7-bin word 1,0,0,1,1,0,1 with a two-cycle stall on the second beat
        q2.push_back(mk(1'b0, 5'd7, 16'h0059, 32'h0, 9'd100, 13'h0));
        drive(1'b1);
        drive(1'b1); beat2("t3_s0",  3'd2, 2'b01, 4'h0, 9'd100, 1'b0, 1'b0);
        drive(1'b0); beat2("t3_s1a", 3'd2, 2'b10, 4'h0, 9'd100, 1'b0, 1'b0);
        drive(1'b0); beat2("t3_s1b", 3'd2, 2'b10, 4'h0, 9'd100, 1'b0, 1'b0);
        drive(1'b1); beat2("t3_s1c", 3'd2, 2'b10, 4'h0, 9'd100, 1'b0, 1'b0);
        drive(1'b1); beat2("t3_s2",  3'd2, 2'b01, 4'h0, 9'd100, 1'b0, 1'b0);
        drive(1'b1); beat2("t3_s3",  3'd1, 2'b01, 4'h0, 9'd100, 1'b0, 1'b1);
        drive(1'b1);
        chk("t3_end_valid", 32'(if2.bin_valid_o), 32'd0);

        // empty non-last word dropped, then a 1-bin last word
        q2.push_back(mk(1'b0, 5'd0, 16'hFFFF, 32'hFFFF_FFFF, 9'd3, 13'h0));
        q2.push_back(mk(1'b1, 5'd1, 16'h0001, 32'h0, 9'd7, 13'h0));
        drive(1'b1);
        drive(1'b1);
        chk("t4_drop_valid", 32'(if2.bin_valid_o), 32'd0);
        chk("t4_drop_wack",  32'(if2.wack_o),      32'd1);
        drive(1'b1); beat2("t4_one", 3'd1, 2'b01, 4'h0, 9'd7, 1'b1, 1'b1);
        drive(1'b1);
        chk("t4_end_valid", 32'(if2.bin_valid_o), 32'd0);

        // zero-bin last word gives one empty last beat
        q2.push_back(mk(1'b1, 5'd0, 16'h0, 32'h0, 9'd42, 13'h1FFF));
        drive(1'b1);
        drive(1'b1); beat2("t4_zero", 3'd0, 2'b00, 4'h0, 9'd42, 1'b1, 1'b1);
        drive(1'b1);
        chk("t4z_end_valid", 32'(if2.bin_valid_o), 32'd0);

        // BPC=4: bin_num 31 saturates to 16, all modes 11 come out as 01
        q4.push_back(mk(1'b1, 5'd31, 16'hA5C3, 32'hFFFF_FFFF, 9'h1FF, 13'h0));
        drive(1'b1);
        drive(1'b1); beat4("t5_b0", 4'h3, 1'b0, 1'b0);
        drive(1'b1); beat4("t5_b1", 4'hC, 1'b0, 1'b0);
        drive(1'b1); beat4("t5_b2", 4'h5, 1'b0, 1'b0);
        drive(1'b1); beat4("t5_b3", 4'hA, 1'b1, 1'b1);
        drive(1'b1);
        chk("t5_end_valid", 32'(if4.bin_valid_o), 32'd0);

        // reset during second beat of a 6-bin word 1,0,1,1,0,1
        q2.push_back(mk(1'b0, 5'd6, 16'h002D, 32'h0, 9'd9, 13'h0));
        drive(1'b1);
        drive(1'b1); beat2("t6_b0", 3'd2, 2'b01, 4'h0, 9'd9, 1'b0, 1'b0);
        drive(1'b0); beat2("t6_b1", 3'd2, 2'b11, 4'h0, 9'd9, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(if2.bin_valid_o), 32'd0);
        chk("t6_rst_cnt",   32'(if2.bin_cnt_o),   32'd0);
        chk("t6_rst_bin",   32'(if2.bin_o),       32'd0);
        chk("t6_rst_ctx",   32'(if2.ctx_o),       32'd0);
        chk("t6_rst_wack",  32'(if2.wack_o),      32'd0);
        @(posedge clk);
        #1 chk("t6_rst_wack_hold", 32'(if2.wack_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("t6_rel_wack", 32'(if2.wack_o), 32'd1);
        q2.push_back(mk(1'b0, 5'd3, 16'h0006, 32'h0, 9'd11, 13'h0));
        drive(1'b1);
        drive(1'b1); beat2("t6_p0", 3'd2, 2'b10, 4'h0, 9'd11, 1'b0, 1'b0);
        drive(1'b1); beat2("t6_p1", 3'd1, 2'b01, 4'h0, 9'd11, 1'b0, 1'b1);
        drive(1'b1);
        chk("t6_end_valid", 32'(if2.bin_valid_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
